full_adder_behavioural: RTL and testbench

//  Behavioural full adder: adds a + b + carry-in c, giving sum and carry-out.
//  sum/carry are purely combinational; a registered copy (sum_q/carry_q) is

---
 rtl/full_adder_behavioural_if.sv | 56 +++++
 rtl/full_adder_behavioural.sv | 87 ++++++++
 tb/tb_full_adder_behavioural.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/full_adder_behavioural_if.sv
// -----------------------------------------------------------------------------
// full_adder_behavioural_if
//
// Purpose:
//   Bundles the operand, carry-in and result signals of full_adder_behavioural
//   so that a producer and the adder connect through a single port.
//
// Parameters:
//   WIDTH    operand / sum width in bits (>= 1)
//
// Signals:
//   a        WIDTH  operand A (unsigned)
//   b        WIDTH  operand B (unsigned)
//   c        1      carry-in
//   sum      WIDTH  combinational sum, (a+b+c) mod 2^WIDTH
//   carry    1      combinational carry-out
//   sum_q    WIDTH  sum registered on rising clk
//   carry_q  1      carry registered on rising clk
//
// Modports:
//   master   drives a/b/c, observes all results
//   slave    the adder: reads a/b/c, drives all results
// -----------------------------------------------------------------------------
interface full_adder_behavioural_if #(
    parameter int unsigned WIDTH = 1
) ();

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;

    modport master (
        output a,
        output b,
        output c,
        input  sum,
        input  carry,
        input  sum_q,
        input  carry_q
    );

    modport slave (
        input  a,
        input  b,
        input  c,
        output sum,
        output carry,
        output sum_q,
        output carry_q
    );

endinterface

// File: rtl/full_adder_behavioural.sv
// -----------------------------------------------------------------------------
// full_adder_behavioural
//
// Purpose:
//   Adds a + b + c. The sum and carry-out are purely combinational; a copy of
//   both is registered on the rising clock edge for pipelined consumers.
//   WIDTH = 1 gives the classic one-bit full adder, larger widths give a
//   ripple-carry adder with c entering at bit 0.
//
// Parameters:
//   WIDTH    operand width in bits (>= 1); must match the interface WIDTH
//
// Ports:
//   clk      rising-edge clock, only used by the registered outputs
//   rst      asynchronous active-high reset, clears sum_q/carry_q only
//   bus      full_adder_behavioural_if.slave
//              in : a, b, c
//              out: sum, carry (combinational), sum_q, carry_q (registered)
// -----------------------------------------------------------------------------
module full_adder_behavioural #(
    parameter int unsigned WIDTH = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    full_adder_behavioural_if.slave        bus
);

    // -------------------------------------------------------------------------
    // Combinational ripple-carry chain
    // -------------------------------------------------------------------------
    // k[i] is the carry into bit i; k[0] is the external carry-in and
    // k[WIDTH] is the carry-out. Plain gate equations are used so that an X
    // or Z on any input propagates to the affected outputs without masking.
    logic [WIDTH:0]   k;
    logic [WIDTH-1:0] sum;
    logic             carry;

    assign k[0] = bus.c;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic ai;
        logic bi;
        logic ki;

        assign ai = bus.a[i];
        assign bi = bus.b[i];
        assign ki = k[i];

        assign sum[i] = ai ^ bi ^ ki;
        // Majority of the three inputs forms the carry into the next bit.
        assign k[i+1] = (ai & bi) | (ai & ki) | (bi & ki);
    end

    assign carry = k[WIDTH];

    assign bus.sum   = sum;
    assign bus.carry = carry;

    // -------------------------------------------------------------------------
    // Registered copy
    // -------------------------------------------------------------------------
    // Reset acts on the registers alone; the combinational path above never
    // sees rst.
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;
    logic             carry_d;
    logic             carry_q;

    always_comb begin
        sum_d   = sum;
        carry_d = carry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign bus.sum_q   = sum_q;
    assign bus.carry_q = carry_q;

endmodule

// File: tb/tb_full_adder_behavioural.sv
// -----------------------------------------------------------------------------
// tb_full_adder_behavioural
//
// Exercises three adder instances (WIDTH = 1, 4 and 8) sharing one clock and
// reset: truth tables from a vector array, register/reset sequences by hand,
// and random WIDTH = 8 vectors against an arithmetic model.
// -----------------------------------------------------------------------------
module tb_full_adder_behavioural;

    logic clk;
    logic clk_en;
    logic rst;

    int unsigned n_total;
    int unsigned n_pass;

    full_adder_behavioural_if #(.WIDTH(1)) bus1 ();
    full_adder_behavioural_if #(.WIDTH(4)) bus4 ();
    full_adder_behavioural_if #(.WIDTH(8)) bus8 ();

    full_adder_behavioural #(.WIDTH(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    full_adder_behavioural #(.WIDTH(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    full_adder_behavioural #(.WIDTH(8)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    initial clk = 1'b0;
    always #5 if (clk_en) clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       c;
        logic [3:0] sum;
        logic       carry;
    } vec_t;

    vec_t w1_vec[8];
    vec_t w4_vec[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        logic [8:0] model;
        logic [8:0] prev;

        n_total = 0;
        n_pass  = 0;

        // WIDTH=1 truth table, index = {a,b,c}
        w1_vec[0] = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0};
        w1_vec[1] = '{4'h0, 4'h0, 1'b1, 4'h1, 1'b0};
        w1_vec[2] = '{4'h0, 4'h1, 1'b0, 4'h1, 1'b0};
        w1_vec[3] = '{4'h0, 4'h1, 1'b1, 4'h0, 1'b1};
        w1_vec[4] = '{4'h1, 4'h0, 1'b0, 4'h1, 1'b0};
        w1_vec[5] = '{4'h1, 4'h0, 1'b1, 4'h0, 1'b1};
        w1_vec[6] = '{4'h1, 4'h1, 1'b0, 4'h0, 1'b1};
        w1_vec[7] = '{4'h1, 4'h1, 1'b1, 4'h1, 1'b1};

        w4_vec[0] = '{4'hF, 4'h1, 1'b0, 4'h0, 1'b1};
        w4_vec[1] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1};
        w4_vec[2] = '{4'h5, 4'h3, 1'b1, 4'h9, 1'b0};
        w4_vec[3] = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0};
        w4_vec[4] = '{4'h8, 4'h8, 1'b0, 4'h0, 1'b1};
        w4_vec[5] = '{4'h7, 4'h8, 1'b1, 4'h0, 1'b1};
        w4_vec[6] = '{4'hA, 4'h4, 1'b0, 4'hE, 1'b0};

        clk_en = 1'b0;
        rst    = 1'b1;
        bus1.a = '0; bus1.b = '0; bus1.c = 1'b0;
        bus4.a = '0; bus4.b = '0; bus4.c = 1'b0;
        bus8.a = '0; bus8.b = '0; bus8.c = 1'b0;
        #10;

        check("rst_w1_sum_q",   32'(bus1.sum_q),   32'h0);
        check("rst_w1_carry_q", 32'(bus1.carry_q), 32'h0);
        check("rst_w8_sum_q",   32'(bus8.sum_q),   32'h0);
        check("rst_w8_carry_q", 32'(bus8.carry_q), 32'h0);

        // Clock idle and reset held: outputs follow inputs, registers stay 0.
        for (int i = 0; i < 8; i++) begin
            bus1.a = w1_vec[i].a[0];
            bus1.b = w1_vec[i].b[0];
            bus1.c = w1_vec[i].c;
            #0;
            check($sformatf("w1_sum[%0d]", i),   32'(bus1.sum),   32'(w1_vec[i].sum[0]));
            check($sformatf("w1_carry[%0d]", i), 32'(bus1.carry), 32'(w1_vec[i].carry));
            #100;
            check($sformatf("w1_sum_q_idle[%0d]", i),   32'(bus1.sum_q),   32'h0);
            check($sformatf("w1_carry_q_idle[%0d]", i), 32'(bus1.carry_q), 32'h0);
        end

        for (int i = 0; i < 7; i++) begin
            bus4.a = w4_vec[i].a;
            bus4.b = w4_vec[i].b;
            bus4.c = w4_vec[i].c;
            #1;
            check($sformatf("w4_sum[%0d]", i),   32'(bus4.sum),   32'(w4_vec[i].sum));
            check($sformatf("w4_carry[%0d]", i), 32'(bus4.carry), 32'(w4_vec[i].carry));
        end

        bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.c = 1'b1;
        #1;
        check("w8_ovf_sum",   32'(bus8.sum),   32'hFF);
        check("w8_ovf_carry", 32'(bus8.carry), 32'h1);
        bus8.a = 8'h00; bus8.b = 8'h00; bus8.c = 1'b1;
        #1;
        check("w8_cin_sum",   32'(bus8.sum),   32'h01);
        check("w8_cin_carry", 32'(bus8.carry), 32'h0);

        // Registered path, one-cycle latency.
        clk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus1.a = 1'b1; bus1.b = 1'b1; bus1.c = 1'b1;
        #1;
        check("reg_pre_edge_sum_q", 32'(bus1.sum_q), 32'h0);
        @(posedge clk);
        #1;
        check("reg_111_sum_q",   32'(bus1.sum_q),   32'h1);
        check("reg_111_carry_q", 32'(bus1.carry_q), 32'h1);
        @(negedge clk);
        bus1.a = 1'b0; bus1.b = 1'b0; bus1.c = 1'b0;
        @(posedge clk);
        #1;
        check("reg_000_sum_q",   32'(bus1.sum_q),   32'h0);
        check("reg_000_carry_q", 32'(bus1.carry_q), 32'h0);

        // Asynchronous reset between edges.
        @(negedge clk);
        bus1.a = 1'b1; bus1.b = 1'b0; bus1.c = 1'b0;
        @(posedge clk);
        #1;
        check("async_loaded_sum_q", 32'(bus1.sum_q), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_sum_q",   32'(bus1.sum_q),   32'h0);
        check("async_rst_carry_q", 32'(bus1.carry_q), 32'h0);
        check("async_rst_comb_sum", 32'(bus1.sum),    32'h1);
        @(posedge clk);
        #1;
        check("async_hold_sum_q", 32'(bus1.sum_q), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        bus1.a = 1'b1; bus1.b = 1'b1; bus1.c = 1'b0;
        @(posedge clk);
        #1;
        check("async_reload_sum_q",   32'(bus1.sum_q),   32'h0);
        check("async_reload_carry_q", 32'(bus1.carry_q), 32'h1);

        // Random WIDTH=8 vectors.
        prev = 9'h0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            bus8.a = ra; bus8.b = rb; bus8.c = rc;
            model = 9'(ra) + 9'(rb) + 9'(rc);
            #1;
            check($sformatf("rnd_comb[%0d] a=%0h b=%0h c=%0h", i, ra, rb, rc),
                  32'({bus8.carry, bus8.sum}), 32'(model));
            if (i > 0) begin
                // Register still holds the previous vector until the next edge.
                check($sformatf("rnd_hold[%0d]", i),
                      32'({bus8.carry_q, bus8.sum_q}), 32'(prev));
            end
            @(posedge clk);
            #1;
            check($sformatf("rnd_reg[%0d] a=%0h b=%0h c=%0h", i, ra, rb, rc),
                  32'({bus8.carry_q, bus8.sum_q}), 32'(model));
            prev = model;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
